// File: rtl/maze_pkg.sv
// Shared maze types: move directions, replay FSM states, cell payload and grid constants.
package maze_pkg;

  localparam int unsigned MAZE_N = 15;
  localparam int unsigned GOAL   = 13;
  localparam int unsigned START  = 1;
  localparam int unsigned CW     = 4;

  typedef enum logic [1:0] {
    DIR_LEFT  = 2'd0,
    DIR_UP    = 2'd1,
    DIR_RIGHT = 2'd2,
    DIR_DOWN  = 2'd3
  } dir_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_COLLECT,
    ST_REPLAY,
    ST_FAIL
  } replay_state_t;

  typedef struct packed {
    logic [CW-1:0] x;
    logic [CW-1:0] y;
  } cell_t;

endpackage

// File: rtl/maze_dir_calc.sv
// Direction of the step from the current cell to the next cell, plus a 4-adjacency flag.
module maze_dir_calc
  import maze_pkg::*;
(
  input  logic [CW-1:0] cur_x_i,
  input  logic [CW-1:0] cur_y_i,
  input  logic [CW-1:0] nxt_x_i,
  input  logic [CW-1:0] nxt_y_i,
  output dir_t          dir_o,
  output logic          adj_o
);

  // Coordinates wrap modulo 16, matching the solver's unsigned arithmetic.
  always_comb begin
    dir_o = DIR_LEFT;
    adj_o = 1'b1;
    if (nxt_y_i == cur_y_i && nxt_x_i == CW'(cur_x_i - CW'(1))) begin
      dir_o = DIR_LEFT;
    end else if (nxt_y_i == cur_y_i && nxt_x_i == CW'(cur_x_i + CW'(1))) begin
      dir_o = DIR_RIGHT;
    end else if (nxt_x_i == cur_x_i && nxt_y_i == CW'(cur_y_i - CW'(1))) begin
      dir_o = DIR_UP;
    end else if (nxt_x_i == cur_x_i && nxt_y_i == CW'(cur_y_i + CW'(1))) begin
      dir_o = DIR_DOWN;
    end else begin
      adj_o = 1'b0;
    end
  end

endmodule

// File: rtl/maze_path_replay.sv
// Buffers the solver's goal-first path in a LIFO and replays it start-to-goal with
// per-beat move direction, path length and sticky error reporting.
module maze_path_replay
  import maze_pkg::*;
#(
  parameter int unsigned DEPTH = 169,
  parameter int unsigned PW    = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic          in_not_valid,
  input  logic [CW-1:0] in_x,
  input  logic [CW-1:0] in_y,
  output logic          busy,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [CW-1:0] out_x,
  output logic [CW-1:0] out_y,
  output logic [1:0]    out_dir,
  output logic          out_last,
  output logic          out_fail,
  output logic [PW-1:0] path_len,
  output logic          err
);

  replay_state_t state_q;
  logic [PW-1:0] count_q, rd_ptr_q, path_len_q;
  cell_t         prev_q;
  cell_t         mem_q [DEPTH];
  logic          busy_q, out_valid_q, out_last_q, out_fail_q, err_q;
  logic [CW-1:0] out_x_q, out_y_q;
  dir_t          out_dir_q;

  cell_t         in_cell_c, ld_cell_c, nx_cell_c, calc_cur_c, calc_nxt_c;
  logic [PW-1:0] ld_ptr_c, nx_ptr_c;
  logic          ld_last_c, calc_adj_c;
  dir_t          calc_dir_c, ld_dir_c;

  assign in_cell_c = {in_x, in_y};

  // ld_ptr is the entry the output register loads next: the top of stack when
  // leaving COLLECT, otherwise the entry below the one currently shown.
  always_comb begin
    ld_ptr_c = '0;
    if (state_q == ST_COLLECT && count_q != '0) begin
      ld_ptr_c = count_q - PW'(1);
    end else if (state_q == ST_REPLAY && rd_ptr_q != '0) begin
      ld_ptr_c = rd_ptr_q - PW'(1);
    end
    nx_ptr_c = (ld_ptr_c != '0) ? ld_ptr_c - PW'(1) : '0;
  end

  assign ld_cell_c = mem_q[ld_ptr_c];
  assign nx_cell_c = mem_q[nx_ptr_c];
  assign ld_last_c = (ld_ptr_c == '0);

  // One direction unit serves both the push adjacency check and the replay annotation.
  always_comb begin
    calc_cur_c = ld_cell_c;
    calc_nxt_c = nx_cell_c;
    if (state_q == ST_COLLECT && in_valid) begin
      calc_cur_c = prev_q;
      calc_nxt_c = in_cell_c;
    end
  end

  maze_dir_calc u_dir_calc (
    .cur_x_i (calc_cur_c.x),
    .cur_y_i (calc_cur_c.y),
    .nxt_x_i (calc_nxt_c.x),
    .nxt_y_i (calc_nxt_c.y),
    .dir_o   (calc_dir_c),
    .adj_o   (calc_adj_c)
  );

  assign ld_dir_c = (ld_last_c || !calc_adj_c) ? DIR_LEFT : calc_dir_c;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      count_q     <= '0;
      rd_ptr_q    <= '0;
      prev_q      <= '0;
      path_len_q  <= '0;
      busy_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_x_q     <= '0;
      out_y_q     <= '0;
      out_dir_q   <= DIR_LEFT;
      out_last_q  <= 1'b0;
      out_fail_q  <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (in_valid) begin
            err_q      <= 1'b0;
            path_len_q <= '0;
            if (in_not_valid) begin
              state_q     <= ST_FAIL;
              busy_q      <= 1'b1;
              out_valid_q <= 1'b1;
              out_fail_q  <= 1'b1;
              out_last_q  <= 1'b1;
              out_x_q     <= '0;
              out_y_q     <= '0;
              out_dir_q   <= DIR_LEFT;
            end else begin
              mem_q[0] <= in_cell_c;
              prev_q   <= in_cell_c;
              count_q  <= PW'(1);
              state_q  <= ST_COLLECT;
            end
          end
        end
        ST_COLLECT: begin
          if (in_valid) begin
            if (in_not_valid || count_q == PW'(DEPTH)) begin
              err_q <= 1'b1;
            end else begin
              mem_q[count_q] <= in_cell_c;
              prev_q         <= in_cell_c;
              count_q        <= count_q + PW'(1);
              if (!calc_adj_c) err_q <= 1'b1;
            end
          end else begin
            state_q     <= ST_REPLAY;
            busy_q      <= 1'b1;
            rd_ptr_q    <= ld_ptr_c;
            path_len_q  <= count_q;
            out_valid_q <= 1'b1;
            out_x_q     <= ld_cell_c.x;
            out_y_q     <= ld_cell_c.y;
            out_dir_q   <= ld_dir_c;
            out_last_q  <= ld_last_c;
          end
        end
        ST_REPLAY: begin
          if (in_valid) err_q <= 1'b1;
          if (out_valid_q && out_ready) begin
            if (out_last_q) begin
              state_q     <= ST_IDLE;
              busy_q      <= 1'b0;
              out_valid_q <= 1'b0;
              out_last_q  <= 1'b0;
              count_q     <= '0;
            end else begin
              rd_ptr_q   <= ld_ptr_c;
              out_x_q    <= ld_cell_c.x;
              out_y_q    <= ld_cell_c.y;
              out_dir_q  <= ld_dir_c;
              out_last_q <= ld_last_c;
            end
          end
        end
        ST_FAIL: begin
          if (in_valid) err_q <= 1'b1;
          if (out_ready) begin
            state_q     <= ST_IDLE;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_fail_q  <= 1'b0;
            out_last_q  <= 1'b0;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign busy      = busy_q;
  assign out_valid = out_valid_q;
  assign out_x     = out_x_q;
  assign out_y     = out_y_q;
  assign out_dir   = out_dir_q;
  assign out_last  = out_last_q;
  assign out_fail  = out_fail_q;
  assign path_len  = path_len_q;
  assign err       = err_q;

endmodule

// File: tb/tb_maze_path_replay.sv
// Scoreboard bench for maze_path_replay: expected replay beats are queued when a path
// is driven and compared as the DUT transfers them.
module tb_maze_path_replay;
  import maze_pkg::*;

  typedef struct packed {
    logic [3:0] x;
    logic [3:0] y;
    logic [1:0] dir;
    logic       last;
    logic       fail;
  } beat_t;

  logic       clk, rst, in_valid, in_not_valid, out_ready;
  logic [3:0] in_x, in_y, out_x, out_y;
  logic [1:0] out_dir;
  logic       busy, out_valid, out_last, out_fail, err;
  logic [7:0] path_len;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  beat_t      sb[$];
  logic [7:0] path_q[$];

  maze_path_replay #(.DEPTH(169), .PW(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_not_valid(in_not_valid),
    .in_x(in_x), .in_y(in_y), .busy(busy), .out_valid(out_valid),
    .out_ready(out_ready), .out_x(out_x), .out_y(out_y), .out_dir(out_dir),
    .out_last(out_last), .out_fail(out_fail), .path_len(path_len), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [1:0] exp_dir(input logic [7:0] cur, input logic [7:0] nxt);
    int cx, cy, nx, ny;
    cx = int'(cur[7:4]); cy = int'(cur[3:0]);
    nx = int'(nxt[7:4]); ny = int'(nxt[3:0]);
    if (ny == cy && nx == cx - 1) return 2'd0;
    if (ny == cy && nx == cx + 1) return 2'd2;
    if (nx == cx && ny == cy - 1) return 2'd1;
    if (nx == cx && ny == cy + 1) return 2'd3;
    return 2'd0;
  endfunction

  // path_q is goal-first; replay runs from the deepest stored entry back to index 0.
  task automatic push_expected();
    int    stored;
    beat_t b;
    stored = (path_q.size() > 169) ? 169 : path_q.size();
    for (int i = stored - 1; i >= 0; i--) begin
      b.x    = path_q[i][7:4];
      b.y    = path_q[i][3:0];
      b.dir  = (i > 0) ? exp_dir(path_q[i], path_q[i-1]) : 2'd0;
      b.last = (i == 0);
      b.fail = 1'b0;
      sb.push_back(b);
    end
  endtask

  task automatic send_path();
    for (int i = 0; i < path_q.size(); i++) begin
      in_valid     = 1'b1;
      in_not_valid = 1'b0;
      in_x         = path_q[i][7:4];
      in_y         = path_q[i][3:0];
      tick();
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while (sb.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    if (sb.size() != 0) begin
      check("drain_timeout", sb.size(), 0);
      sb.delete();
    end
    tick();
  endtask

  // Transfer checker plus stability check on every stalled beat.
  logic  hold_q = 1'b0, skip_q = 1'b0;
  beat_t held;
  always @(negedge clk) begin
    beat_t e, cur;
    cur = '{x: out_x, y: out_y, dir: out_dir, last: out_last, fail: out_fail};
    if (rst) begin
      hold_q = 1'b0;
      skip_q = 1'b1;
    end else begin
      if (hold_q && !skip_q) begin
        check("hold_valid", out_valid, 1);
        check("hold_beat", cur, held);
      end
      skip_q = 1'b0;
      if (out_valid && out_ready) begin
        if (sb.size() == 0) check("extra_beat", 1, 0);
        else begin
          e = sb.pop_front();
          check("beat_x", out_x, e.x);
          check("beat_y", out_y, e.y);
          check("beat_dir", out_dir, e.dir);
          check("beat_last", out_last, e.last);
          check("beat_fail", out_fail, e.fail);
        end
      end
      hold_q = out_valid && !out_ready;
      held   = cur;
    end
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_valid"}, out_valid, 0);
    check({tag, "_xy"}, {out_x, out_y}, 0);
    check({tag, "_dir"}, out_dir, 0);
    check({tag, "_last_fail"}, {out_last, out_fail}, 0);
    check({tag, "_len"}, path_len, 0);
    check({tag, "_err"}, err, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    beat_t fb;
    logic  rdy_pat [4];
    int    k;
    rdy_pat = '{1'b1, 1'b0, 1'b0, 1'b1};
    rst = 1'b1; in_valid = 1'b0; in_not_valid = 1'b0; in_x = '0; in_y = '0; out_ready = 1'b0;
    tick(); tick();
    check_all_zero("reset");
    rst = 1'b0;
    tick();

    // Straight path: down column 13, then along row 1 to the start.
    path_q.delete();
    for (int y = GOAL; y >= 1; y--) path_q.push_back({4'(GOAL), 4'(y)});
    for (int x = GOAL - 1; x >= START; x--) path_q.push_back({4'(x), 4'(START)});
    push_expected();
    out_ready = 1'b1;
    send_path();
    check("straight_latency1", out_valid, 0);
    tick();
    check("straight_latency2", out_valid, 1);
    check("straight_busy", busy, 1);
    check("straight_len", path_len, 25);
    wait_drain(60);
    check("straight_err", err, 0);
    check("straight_len_hold", path_len, 25);
    check("straight_idle", {busy, out_valid}, 0);

    // Unsolvable maze held under backpressure.
    out_ready = 1'b0;
    in_valid = 1'b1; in_not_valid = 1'b1; in_x = 4'd3; in_y = 4'd3;
    fb = '{x: 4'd0, y: 4'd0, dir: 2'd0, last: 1'b1, fail: 1'b1};
    sb.push_back(fb);
    tick();
    in_valid = 1'b0; in_not_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("fail_valid", out_valid, 1);
      check("fail_flags", {out_fail, out_last}, 2'b11);
      check("fail_len", path_len, 0);
      tick();
    end
    out_ready = 1'b1;
    wait_drain(5);
    check("fail_idle", {busy, out_valid}, 0);

    // Backpressure on a short bent path.
    out_ready = 1'b0;
    path_q.delete();
    path_q.push_back({4'd2, 4'd2});
    path_q.push_back({4'd2, 4'd1});
    path_q.push_back({4'd1, 4'd1});
    push_expected();
    send_path();
    tick();
    k = 0;
    while (sb.size() != 0 && k < 40) begin
      out_ready = rdy_pat[k % 4];
      tick();
      k++;
    end
    check("bp_drained", sb.size(), 0);
    sb.delete();
    out_ready = 1'b1;
    tick();
    check("bp_err", err, 0);
    check("bp_len", path_len, 3);

    // Non-adjacent jump from (5,5) to (7,5).
    path_q.delete();
    path_q.push_back({4'd7, 4'd6});
    path_q.push_back({4'd7, 4'd5});
    path_q.push_back({4'd5, 4'd5});
    path_q.push_back({4'd5, 4'd4});
    push_expected();
    send_path();
    wait_drain(20);
    check("jump_err", err, 1);
    check("jump_len", path_len, 4);

    // Overflow: 169-cell snake plus one extra beat, then a beat injected mid-replay.
    path_q.delete();
    for (int y = GOAL; y >= START; y--) begin
      for (int j = 0; j < 13; j++) begin
        int x;
        x = (y % 2 == 1) ? (GOAL - j) : (START + j);
        path_q.push_back({4'(x), 4'(y)});
      end
    end
    path_q.push_back({4'd1, 4'd2});
    push_expected();
    send_path();
    tick();
    check("ovf_len", path_len, 169);
    check("ovf_err", err, 1);
    for (int i = 0; i < 5; i++) tick();
    check("ovf_busy", busy, 1);
    in_valid = 1'b1; in_x = 4'd1; in_y = 4'd1;
    tick();
    in_valid = 1'b0;
    wait_drain(400);
    check("ovf_err_hold", err, 1);
    check("ovf_len_hold", path_len, 169);
    check("ovf_idle", {busy, out_valid}, 0);

    // Reset in the middle of a replay, then a fresh 2-cell path.
    out_ready = 1'b0;
    path_q.delete();
    path_q.push_back({4'd4, 4'd4});
    path_q.push_back({4'd4, 4'd3});
    path_q.push_back({4'd4, 4'd2});
    path_q.push_back({4'd4, 4'd1});
    send_path();
    tick(); tick(); tick();
    check("pre_rst_valid", out_valid, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_all_zero("mid_rst");
    path_q.delete();
    path_q.push_back({4'd3, 4'd4});
    path_q.push_back({4'd3, 4'd3});
    push_expected();
    out_ready = 1'b1;
    send_path();
    wait_drain(20);
    check("post_rst_len", path_len, 2);
    check("post_rst_err", err, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
